// File: rtl/fifo_drain_pkg.sv
// Shared constants and types for the fifo_drain read-side engine.
package fifo_drain_pkg;
    localparam int SKID_DEPTH = 2;
    localparam int BEAT_CNT_W = 16;
    typedef logic [1:0] buf_cnt_t;
endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry ordered skid buffer: entry 0 is always the oldest word.
module fifo_drain_skid
    import fifo_drain_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] head,
    output buf_cnt_t     cnt
);
    logic [SKID_DEPTH-1:0][W-1:0] ent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent <= '0;
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) ent[0] <= push_data;
                    else             ent[1] <= push_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent[0] <= ent[1];
                    cnt    <= cnt - 2'd1;
                end
                2'b11: begin
                    // Head leaves; the older survivor (or the new word) becomes head.
                    if (cnt == 2'd2) begin
                        ent[0] <= ent[1];
                        ent[1] <= push_data;
                    end else begin
                        ent[0] <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = ent[0];
endmodule

// File: rtl/fifo_drain.sv
// FIFO read-side drain: request logic, skid staging, burst marking, sticky underflow.
// Optional beat statistics counter enabled by defining FIFO_DRAIN_STATS_EN.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  underflow_err,
    output logic [BEAT_CNT_W-1:0] beat_cnt
);
    localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

    logic             inflight;
    buf_cnt_t         buf_cnt;
    logic [IDX_W-1:0] beat_idx;
    logic [2:0]       occ;
    logic             pop;
    logic             push;

    // Occupancy counts the word in flight so a returning word always has a slot.
    assign occ        = {1'b0, buf_cnt} + {2'b00, inflight};
    assign pop        = m_valid && m_ready;
    assign push       = inflight && !fifo_underflow;
    assign fifo_rd_en = rst_n && !fifo_empty &&
                        ((occ < 3'd2) || ((occ == 3'd2) && pop));

    assign m_valid = (buf_cnt != 2'd0);
    assign m_last  = m_valid && (beat_idx == LAST_IDX);

    fifo_drain_skid #(.W(FIFO_WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (fifo_data_out),
        .head      (m_data),
        .cnt       (buf_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            underflow_err <= 1'b0;
            beat_idx      <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (inflight && fifo_underflow) underflow_err <= 1'b1;
            if (pop) begin
                if (beat_idx == LAST_IDX) beat_idx <= '0;
                else                      beat_idx <= beat_idx + 1'b1;
            end
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    logic [BEAT_CNT_W-1:0] beat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   beat_q <= '0;
        else if (pop) beat_q <= beat_q + 1'b1;
    end

    assign beat_cnt = beat_q;
`else
    assign beat_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain with a behavioural FIFO model on the read side.
module tb_fifo_drain;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty;
    logic        fifo_underflow = 1'b0;
    logic [15:0] fifo_data_out = '0;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic        underflow_err;
    logic [15:0] beat_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];
    int wptr = 0;
    int rptr = 0;

    always #5 clk = ~clk;

    fifo_drain #(.FIFO_WIDTH(16), .BURST_LEN(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_last         (m_last),
        .m_ready        (m_ready),
        .underflow_err  (underflow_err),
        .beat_cnt       (beat_cnt)
    );

    // FIFO model: registered read data, flushed by the shared reset.
    assign fifo_empty = (wptr == rptr);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr          <= wptr;
            fifo_data_out <= '0;
        end else if (fifo_rd_en && (wptr != rptr)) begin
            fifo_data_out <= mem[rptr[7:0]];
            rptr          <= rptr + 1;
        end
    end

    task automatic push_word(input logic [15:0] d);
        mem[wptr[7:0]] = d;
        wptr = wptr + 1;
    endtask

    task automatic do_reset();
        m_ready = 1'b0;
        fifo_underflow = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({m_valid, m_last, underflow_err, fifo_rd_en} !== 4'b0 || m_data !== 16'h0 || beat_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b last=%b err=%b rd=%b data=%h cnt=%0d, required all 0",
                     m_valid, m_last, underflow_err, fifo_rd_en, m_data, beat_cnt);
        end
        @(negedge clk);
        for (int i = 1; i <= 4; i++) push_word(16'(i));
        repeat (4) @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h0001) begin
            errors++;
            $display("FAIL reset_prefill: valid=%b data=%h, required 1 0001", m_valid, m_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, fifo_rd_en} !== 3'b0 || m_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_async: valid=%b last=%b rd=%b data=%h, required 0", m_valid, m_last, fifo_rd_en, m_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_word(16'h00a1);
        push_word(16'h00a2);
        #1;
        checks++;
        if (fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_rd: rd=%b, required 1", fifo_rd_en);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_latency1: valid=%b, required 0", m_valid);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'h00a1) begin
            errors++;
            $display("FAIL reset_latency2: valid=%b data=%h, required 1 00a1", m_valid, m_data);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_lat: valid=%b, required 0", m_valid);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== 16'(k) || m_last !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL stream_beat%0d: valid=%b data=%h last=%b, required 1 %h %b",
                         k, m_valid, m_data, m_last, 16'(k), (k % 4 == 0));
            end
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drained: valid=%b, required 0", m_valid);
        end
    endtask

    task automatic test_backpressure();
        int rd_cnt = 0;
        do_reset();
        for (int i = 1; i <= 4; i++) push_word(16'(i));
        m_ready = 1'b0;
        #1;
        if (fifo_rd_en) rd_cnt++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (fifo_rd_en) rd_cnt++;
            checks++;
            if (c >= 2 && (m_valid !== 1'b1 || m_data !== 16'h0001 || m_last !== 1'b0)) begin
                errors++;
                $display("FAIL bp_stall_c%0d: valid=%b data=%h last=%b, required 1 0001 0", c, m_valid, m_data, m_last);
            end
        end
        checks++;
        if (rd_cnt != 2) begin
            errors++;
            $display("FAIL bp_reads: got %0d reads, required 2", rd_cnt);
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL bp_rd_reassert: rd=%b, required 1", fifo_rd_en);
        end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 16'(k) || m_last !== (k == 4)) begin
                errors++;
                $display("FAIL bp_beat%0d: valid=%b data=%h last=%b, required 1 %h %b",
                         k, m_valid, m_data, m_last, 16'(k), (k == 4));
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: valid=%b, required 0", m_valid);
        end
    endtask

    task automatic test_alternating();
        int got = 0;
        do_reset();
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        for (int i = 0; i < 40; i++) begin
            m_ready = (i % 2 == 1);
            #1;
            if (dut.buf_cnt > 2'd2) begin
                errors++;
                $display("FAIL alt_bufcnt: buf_cnt=%0d, required <= 2", dut.buf_cnt);
            end
            if (m_valid) begin
                checks++;
                if (m_data !== 16'(got + 1) || m_last !== (got % 4 == 3)) begin
                    errors++;
                    $display("FAIL alt_beat%0d: data=%h last=%b, required %h %b",
                             got + 1, m_data, m_last, 16'(got + 1), (got % 4 == 3));
                end
                if (m_ready) got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL alt_count: received %0d words, required 8", got);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        fifo_underflow = 1'b1;
        @(negedge clk);
        fifo_underflow = 1'b0;
        #1;
        checks++;
        if (underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL uf_ignored: err=%b, required 0", underflow_err);
        end
        @(negedge clk);
        push_word(16'h0001);
        push_word(16'h0002);
        push_word(16'h0003);
        m_ready = 1'b1;
        @(negedge clk);
        fifo_underflow = 1'b1;
        @(negedge clk);
        fifo_underflow = 1'b0;
        #1;
        checks++;
        if (underflow_err !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL uf_drop: err=%b valid=%b, required 1 0", underflow_err, m_valid);
        end
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== 16'(k)) begin
                errors++;
                $display("FAIL uf_next%0d: valid=%b data=%h, required 1 %h", k, m_valid, m_data, 16'(k));
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (underflow_err !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL uf_sticky: err=%b valid=%b, required 1 0", underflow_err, m_valid);
        end
        do_reset();
        #1;
        checks++;
        if (underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL uf_clear: err=%b, required 0", underflow_err);
        end
    endtask

    task automatic test_stats();
        logic [15:0] exp_cnt;
`ifdef FIFO_DRAIN_STATS_EN
        exp_cnt = 16'd4464;
`else
        exp_cnt = 16'd0;
`endif
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            push_word(16'(i));
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (beat_cnt !== exp_cnt || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stats_cnt: beat_cnt=%0d valid=%b, required %0d 0", beat_cnt, m_valid, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_alternating();
        test_underflow();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
